// File: rtl/mc_ctrl_fsm_if.sv
// Bus bundle between the multicycle controller and the rest of the core:
// instruction fields, status flags, memory handshake and all control lines.
interface mc_ctrl_fsm_if #(
  parameter int ICNT_W = 16
) ();

  // Instruction fields and flags (driven by IR / status register)
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        cond;
  logic              N;
  logic              V;
  logic              Z;
  logic              mem_ready;

  // Register file and datapath controls
  logic [2:0]        nsel;
  logic [1:0]        vsel;
  logic              loada;
  logic              loadb;
  logic              loadc;
  logic              loads;
  logic              write;
  logic              asel;
  logic              bsel;

  // Fetch, PC and memory interface controls
  logic              load_ir;
  logic              load_pc;
  logic              reset_pc;
  logic              addr_sel;
  logic              load_addr;
  logic [1:0]        pc_sel;
  logic [1:0]        mem_cmd;

  // Sticky status and statistics
  logic              halt;
  logic              err;
  logic [ICNT_W-1:0] instr_count;

  // Core side: supplies instruction fields/flags, consumes controls
  modport master (
    output opcode, op, cond, N, V, Z, mem_ready,
    input  nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
    input  load_ir, load_pc, reset_pc, addr_sel, load_addr, pc_sel, mem_cmd,
    input  halt, err, instr_count
  );

  // Controller side
  modport slave (
    input  opcode, op, cond, N, V, Z, mem_ready,
    output nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
    output load_ir, load_pc, reset_pc, addr_sel, load_addr, pc_sel, mem_cmd,
    output halt, err, instr_count
  );

endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit RISC core. Sequences fetch, decode,
// ALU, load/store and branch micro-ops with a timed memory handshake, an
// error trap and a retired-instruction counter. All controls are registered
// and are a pure function of the state they accompany (Moore).
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int ICNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  mc_ctrl_fsm_if.slave bus
);

  typedef enum logic [4:0] {
    S_RESET, S_IF1, S_IF2, S_UPDPC, S_DEC,
    S_GETA, S_GETB, S_GETD, S_EXEC, S_WRB,
    S_CMPX, S_WRIMM, S_ADDR, S_LADDR, S_MRD,
    S_WRM, S_MWR, S_LINK, S_BRT, S_BRX,
    S_HALT, S_ERR
  } state_t;

  // Complete control word; registered as a unit so every output is a flop.
  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic       bsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] pc_sel;
    logic [1:0] mem_cmd;
    logic       halt;
    logic       err;
  } ctrl_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [2:0] SEL_RN = 3'b001;
  localparam logic [2:0] SEL_RD = 3'b010;
  localparam logic [2:0] SEL_RM = 3'b100;

  localparam logic [1:0] VS_C     = 2'b00;
  localparam logic [1:0] VS_PC    = 2'b01;
  localparam logic [1:0] VS_IMM   = 2'b10;
  localparam logic [1:0] VS_MDATA = 2'b11;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  // Last wait count before the memory watchdog fires (unused when disabled)
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;
  ctrl_t             ctrl_q, ctrl_d;

  logic [4:0] instr;
  logic is_movimm, is_movreg, is_alu2, is_cmp, is_mvn;
  logic is_ldr, is_str, is_b, is_bl, is_bx, is_blx, is_halt;
  logic cond_ok, br_taken, exec_asel, timeout_hit, mem_state;

  // Control word for a state; exec_a selects the EXEC A-operand bypass.
  function automatic ctrl_t ctrl_of(input state_t s, input logic exec_a);
    ctrl_t c;
    c = '0;
    case (s)
      S_RESET: begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = CMD_READ; end
      S_IF2:   begin c.addr_sel = 1'b1; c.load_ir = 1'b1; end
      S_UPDPC: begin c.load_pc = 1'b1; c.pc_sel = PC_INC; end
      S_GETA:  begin c.nsel = SEL_RN; c.loada = 1'b1; end
      S_GETB:  begin c.nsel = SEL_RM; c.loadb = 1'b1; end
      S_GETD:  begin c.nsel = SEL_RD; c.loadb = 1'b1; end
      S_EXEC:  begin c.loadc = 1'b1; c.asel = exec_a; end
      S_WRB:   begin c.nsel = SEL_RD; c.vsel = VS_C; c.write = 1'b1; end
      S_CMPX:  c.loads = 1'b1;
      S_WRIMM: begin c.nsel = SEL_RN; c.vsel = VS_IMM; c.write = 1'b1; end
      S_ADDR:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LADDR: c.load_addr = 1'b1;
      S_MRD:   c.mem_cmd = CMD_READ;
      S_WRM:   begin c.nsel = SEL_RD; c.vsel = VS_MDATA; c.write = 1'b1; end
      S_MWR:   c.mem_cmd = CMD_WRITE;
      S_LINK:  begin c.nsel = SEL_RN; c.vsel = VS_PC; c.write = 1'b1; end
      S_BRT:   begin c.load_pc = 1'b1; c.pc_sel = PC_REL; end
      S_BRX:   begin c.load_pc = 1'b1; c.pc_sel = PC_REG; end
      S_HALT:  c.halt = 1'b1;
      S_ERR:   c.err = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instruction classification from IR fields (stable outside IF2)
  always_comb begin
    instr     = {bus.opcode, bus.op};
    is_movimm = (instr == 5'b110_10);
    is_movreg = (instr == 5'b110_00);
    is_alu2   = (instr == 5'b101_00) || (instr == 5'b101_10);
    is_cmp    = (instr == 5'b101_01);
    is_mvn    = (instr == 5'b101_11);
    is_ldr    = (instr == 5'b011_00);
    is_str    = (instr == 5'b100_00);
    is_b      = (instr == 5'b001_00);
    is_bl     = (instr == 5'b010_11);
    is_bx     = (instr == 5'b010_00);
    is_blx    = (instr == 5'b010_10);
    is_halt   = (bus.opcode == 3'b111);
    exec_asel = is_movreg | is_mvn | is_str | is_bx | is_blx;
  end

  // Branch condition evaluation on the flags seen during DEC
  always_comb begin
    cond_ok  = 1'b1;
    br_taken = 1'b0;
    case (bus.cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = bus.Z;
      3'b010:  br_taken = ~bus.Z;
      3'b011:  br_taken = bus.N ^ bus.V;
      3'b100:  br_taken = (bus.N ^ bus.V) | bus.Z;
      default: cond_ok  = 1'b0;
    endcase
  end

  // Next state, wait counter, retire counter and next control word
  always_comb begin
    mem_state   = (state_q == S_IF1) || (state_q == S_MRD) || (state_q == S_MWR);
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == TO_LAST);
    state_d     = state_q;

    case (state_q)
      S_RESET: state_d = S_IF1;
      S_IF1: begin
        if (bus.mem_ready)    state_d = S_IF2;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_IF2:   state_d = S_UPDPC;
      S_UPDPC: state_d = S_DEC;
      S_DEC: begin
        if (is_movimm)                               state_d = S_WRIMM;
        else if (is_movreg || is_mvn)                state_d = S_GETB;
        else if (is_alu2 || is_cmp || is_ldr || is_str) state_d = S_GETA;
        else if (is_b) begin
          if (!cond_ok)      state_d = S_ERR;
          else if (br_taken) state_d = S_BRT;
          else               state_d = S_IF1;
        end
        else if (is_bl || is_blx) state_d = S_LINK;
        else if (is_bx)           state_d = S_GETD;
        else if (is_halt)         state_d = S_HALT;
        else                      state_d = S_ERR;
      end
      S_GETA:  state_d = (is_ldr || is_str) ? S_ADDR : S_GETB;
      S_GETB:  state_d = is_cmp ? S_CMPX : S_EXEC;
      S_GETD:  state_d = S_EXEC;
      S_EXEC: begin
        if (is_str)               state_d = S_MWR;
        else if (is_bx || is_blx) state_d = S_BRX;
        else                      state_d = S_WRB;
      end
      S_WRB, S_CMPX, S_WRIMM, S_WRM, S_BRT, S_BRX: state_d = S_IF1;
      S_ADDR:  state_d = S_LADDR;
      S_LADDR: state_d = is_str ? S_GETD : S_MRD;
      S_MRD: begin
        if (bus.mem_ready)    state_d = S_WRM;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_MWR: begin
        if (bus.mem_ready)    state_d = S_IF1;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_LINK:  state_d = is_bl ? S_BRT : S_GETD;
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Waiting is the only way to stay in a memory state, so any
    // self-loop there counts a stalled cycle; every entry starts at 0.
    if (mem_state && (state_d == state_q)) wait_cnt_d = wait_cnt_q + TO_W'(1);
    else                                   wait_cnt_d = '0;

    // Retire on each return to fetch, except the first fetch after reset
    if ((state_d == S_IF1) && (state_q != S_IF1) && (state_q != S_RESET))
      icnt_d = icnt_q + ICNT_W'(1);
    else
      icnt_d = icnt_q;

    ctrl_d = ctrl_of(state_d, exec_asel);
  end

  // State, counters and registered controls; reset forces RESET outputs at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      icnt_q     <= '0;
      ctrl_q     <= ctrl_of(S_RESET, 1'b0);
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      icnt_q     <= icnt_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign bus.nsel        = ctrl_q.nsel;
  assign bus.vsel        = ctrl_q.vsel;
  assign bus.loada       = ctrl_q.loada;
  assign bus.loadb       = ctrl_q.loadb;
  assign bus.loadc       = ctrl_q.loadc;
  assign bus.loads       = ctrl_q.loads;
  assign bus.write       = ctrl_q.write;
  assign bus.asel        = ctrl_q.asel;
  assign bus.bsel        = ctrl_q.bsel;
  assign bus.load_ir     = ctrl_q.load_ir;
  assign bus.load_pc     = ctrl_q.load_pc;
  assign bus.reset_pc    = ctrl_q.reset_pc;
  assign bus.addr_sel    = ctrl_q.addr_sel;
  assign bus.load_addr   = ctrl_q.load_addr;
  assign bus.pc_sel      = ctrl_q.pc_sel;
  assign bus.mem_cmd     = ctrl_q.mem_cmd;
  assign bus.halt        = ctrl_q.halt;
  assign bus.err         = ctrl_q.err;
  assign bus.instr_count = icnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks instruction sequences cycle by cycle
// and compares the full control word against hand-written per-state values.
module tb_mc_ctrl_fsm;

  localparam int ST_RESET = 0,  ST_IF1 = 1,   ST_IF2 = 2,   ST_UPDPC = 3;
  localparam int ST_DEC   = 4,  ST_GETA = 5,  ST_GETB = 6,  ST_GETD = 7;
  localparam int ST_EXEC  = 8,  ST_WRB = 9,   ST_CMPX = 10, ST_WRIMM = 11;
  localparam int ST_ADDR  = 12, ST_LADDR = 13, ST_MRD = 14, ST_WRM = 15;
  localparam int ST_MWR   = 16, ST_LINK = 17, ST_BRT = 18,  ST_BRX = 19;
  localparam int ST_HALT  = 20, ST_ERR = 21;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   seq[$];

  mc_ctrl_fsm_if #(.ICNT_W(16)) bus ();

  mc_ctrl_fsm #(.MEM_TIMEOUT(15), .TO_W(4), .ICNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word, packed in a fixed field order
  logic [22:0] obs;
  assign obs = {bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.write, bus.asel, bus.bsel, bus.load_ir, bus.load_pc,
                bus.reset_pc, bus.addr_sel, bus.load_addr, bus.pc_sel,
                bus.mem_cmd, bus.halt, bus.err};

  // Required control word for each state
  function automatic logic [22:0] exp_sig(input int st, input logic a);
    logic [2:0] ns;
    logic [1:0] vs, pcs, mc;
    logic la, lb, lc, ls, wr, as, bs, lir, lpc, rpc, ads, lad, h, e;
    ns = 3'b000; vs = 2'b00; pcs = 2'b00; mc = 2'b00;
    la = 0; lb = 0; lc = 0; ls = 0; wr = 0; as = 0; bs = 0;
    lir = 0; lpc = 0; rpc = 0; ads = 0; lad = 0; h = 0; e = 0;
    case (st)
      ST_RESET: begin rpc = 1; lpc = 1; end
      ST_IF1:   begin ads = 1; mc = 2'b01; end
      ST_IF2:   begin ads = 1; lir = 1; end
      ST_UPDPC: begin lpc = 1; pcs = 2'b00; end
      ST_GETA:  begin ns = 3'b001; la = 1; end
      ST_GETB:  begin ns = 3'b100; lb = 1; end
      ST_GETD:  begin ns = 3'b010; lb = 1; end
      ST_EXEC:  begin lc = 1; as = a; end
      ST_WRB:   begin ns = 3'b010; vs = 2'b00; wr = 1; end
      ST_CMPX:  ls = 1;
      ST_WRIMM: begin ns = 3'b001; vs = 2'b10; wr = 1; end
      ST_ADDR:  begin bs = 1; lc = 1; end
      ST_LADDR: lad = 1;
      ST_MRD:   mc = 2'b01;
      ST_WRM:   begin ns = 3'b010; vs = 2'b11; wr = 1; end
      ST_MWR:   mc = 2'b10;
      ST_LINK:  begin ns = 3'b001; vs = 2'b01; wr = 1; end
      ST_BRT:   begin lpc = 1; pcs = 2'b01; end
      ST_BRX:   begin lpc = 1; pcs = 2'b10; end
      ST_HALT:  h = 1;
      ST_ERR:   e = 1;
      default:  ;
    endcase
    return {ns, vs, la, lb, lc, ls, wr, as, bs, lir, lpc, rpc, ads, lad, pcs, mc, h, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_chk++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; sample point is the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Step through the states in seq, checking the control word in each
  task automatic run_seq(input string name, input logic a);
    for (int i = 0; i < seq.size(); i++) begin
      step();
      chk($sformatf("%s[%0d]", name, i), {9'd0, obs}, {9'd0, exp_sig(seq[i], a)});
    end
  endtask

  task automatic set_instr(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c);
    bus.opcode = opc;
    bus.op     = o;
    bus.cond   = c;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.N = 0; bus.V = 0; bus.Z = 0;
    bus.mem_ready = 1'b1;
    set_instr(3'b101, 2'b00, 3'b000);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_sig", {9'd0, obs}, {9'd0, exp_sig(ST_RESET, 0)});
    chk("reset_icnt", 32'(bus.instr_count), 32'd0);

    // ADD: 8 cycles, then back to IF1 with one retired instruction
    reset = 1'b0;
    seq = '{ST_IF1, ST_IF2, ST_UPDPC, ST_DEC, ST_GETA, ST_GETB, ST_EXEC, ST_WRB, ST_IF1};
    run_seq("add", 1'b0);
    chk("add_icnt", 32'(bus.instr_count), 32'd1);

    // LDR with three stalled cycles in MRD
    set_instr(3'b011, 2'b00, 3'b000);
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_GETA, ST_ADDR, ST_LADDR};
    run_seq("ldr", 1'b0);
    bus.mem_ready = 1'b0;
    seq = '{ST_MRD, ST_MRD, ST_MRD, ST_MRD};
    run_seq("ldr_wait", 1'b0);
    bus.mem_ready = 1'b1;
    seq = '{ST_WRM, ST_IF1};
    run_seq("ldr_wb", 1'b0);
    chk("ldr_icnt", 32'(bus.instr_count), 32'd2);

    // CMP
    set_instr(3'b101, 2'b01, 3'b000);
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_GETA, ST_GETB, ST_CMPX, ST_IF1};
    run_seq("cmp", 1'b0);
    chk("cmp_icnt", 32'(bus.instr_count), 32'd3);

    // STR stalled in MWR, then aborted by an asynchronous reset mid-cycle
    set_instr(3'b100, 2'b00, 3'b000);
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_GETA, ST_ADDR, ST_LADDR, ST_GETD, ST_EXEC};
    run_seq("str", 1'b1);
    bus.mem_ready = 1'b0;
    seq = '{ST_MWR, ST_MWR};
    run_seq("str_wait", 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_sig", {9'd0, obs}, {9'd0, exp_sig(ST_RESET, 0)});
    chk("async_reset_icnt", 32'(bus.instr_count), 32'd0);
    @(negedge clk);
    chk("reset_hold_sig", {9'd0, obs}, {9'd0, exp_sig(ST_RESET, 0)});

    // Branches: BEQ taken, BEQ not taken, BLT taken, then BLX and MOV imm
    bus.mem_ready = 1'b1;
    set_instr(3'b001, 2'b00, 3'b001);
    bus.Z = 1'b1;
    reset = 1'b0;
    seq = '{ST_IF1, ST_IF2, ST_UPDPC, ST_DEC, ST_BRT, ST_IF1};
    run_seq("beq_taken", 1'b0);
    chk("beq_icnt", 32'(bus.instr_count), 32'd1);
    bus.Z = 1'b0;
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_IF1};
    run_seq("beq_not", 1'b0);
    chk("beq_not_icnt", 32'(bus.instr_count), 32'd2);
    set_instr(3'b001, 2'b00, 3'b011);
    bus.N = 1'b1;
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_BRT, ST_IF1};
    run_seq("blt_taken", 1'b0);
    bus.N = 1'b0;
    set_instr(3'b010, 2'b10, 3'b000);
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_LINK, ST_GETD, ST_EXEC, ST_BRX, ST_IF1};
    run_seq("blx", 1'b1);
    set_instr(3'b110, 2'b10, 3'b000);
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_WRIMM, ST_IF1};
    run_seq("movimm", 1'b0);
    chk("movimm_icnt", 32'(bus.instr_count), 32'd5);

    // Undefined branch condition traps, and the trap is sticky
    set_instr(3'b001, 2'b00, 3'b110);
    seq = '{ST_IF2, ST_UPDPC, ST_DEC, ST_ERR, ST_ERR, ST_ERR, ST_ERR};
    run_seq("bad_cond", 1'b0);
    chk("bad_cond_icnt", 32'(bus.instr_count), 32'd5);

    // Fetch timeout: 15 cycles in IF1 without mem_ready, then ERR
    reset = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk($sformatf("timeout_if1[%0d]", i), {9'd0, obs}, {9'd0, exp_sig(ST_IF1, 0)});
    end
    seq = '{ST_ERR, ST_ERR, ST_ERR, ST_ERR, ST_ERR};
    run_seq("timeout_err", 1'b0);
    bus.mem_ready = 1'b1;
    step();
    chk("timeout_err_sticky", 32'(bus.err), 32'd1);
    chk("timeout_icnt", 32'(bus.instr_count), 32'd0);

    // HALT persists until reset
    reset = 1'b1;
    @(negedge clk);
    chk("err_cleared", 32'(bus.err), 32'd0);
    set_instr(3'b111, 2'b01, 3'b000);
    reset = 1'b0;
    seq = '{ST_IF1, ST_IF2, ST_UPDPC, ST_DEC, ST_HALT};
    run_seq("halt", 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("halt_hold[%0d]", i), {9'd0, obs}, {9'd0, exp_sig(ST_HALT, 0)});
    end
    reset = 1'b1;
    #1;
    chk("halt_cleared", {9'd0, obs}, {9'd0, exp_sig(ST_RESET, 0)});
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
